// File: rtl/mold_feed_arb.sv
// mold_feed_arb: packet-level round-robin arbiter sharing one MoldUDP64
// parser between redundant UDP feeds A and B, with debug counters.
//
// Ports:
//   clk, nreset                    clock, async active-low reset
//   a_axis_* / b_axis_*            feed A / feed B AXI-stream inputs (+tready out)
//   upd_axis_*                     muxed AXI-stream to the parser (+tready in)
//   grant_o                        one-hot grant: [0]=A, [1]=B, 00=idle
//   pkt_a_cnt_o, pkt_b_cnt_o       packets completed per feed (wrapping)
//   err_cnt_o                      packets completed with tuser on any beat
module mold_feed_arb #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  a_axis_tvalid_i,
    input  logic [AXI_KEEP_W-1:0] a_axis_tkeep_i,
    input  logic [AXI_DATA_W-1:0] a_axis_tdata_i,
    input  logic                  a_axis_tlast_i,
    input  logic                  a_axis_tuser_i,
    output logic                  a_axis_tready_o,
    input  logic                  b_axis_tvalid_i,
    input  logic [AXI_KEEP_W-1:0] b_axis_tkeep_i,
    input  logic [AXI_DATA_W-1:0] b_axis_tdata_i,
    input  logic                  b_axis_tlast_i,
    input  logic                  b_axis_tuser_i,
    output logic                  b_axis_tready_o,
    output logic                  upd_axis_tvalid_o,
    output logic [AXI_KEEP_W-1:0] upd_axis_tkeep_o,
    output logic [AXI_DATA_W-1:0] upd_axis_tdata_o,
    output logic                  upd_axis_tlast_o,
    output logic                  upd_axis_tuser_o,
    input  logic                  upd_axis_tready_i,
    output logic [1:0]            grant_o,
    output logic [CNT_W-1:0]      pkt_a_cnt_o,
    output logic [CNT_W-1:0]      pkt_b_cnt_o,
    output logic [CNT_W-1:0]      err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             err_seen_q, err_seen_d;
    logic [CNT_W-1:0] pkt_a_q, pkt_a_d;
    logic [CNT_W-1:0] pkt_b_q, pkt_b_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             xfer;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            err_seen_q <= 1'b0;
            pkt_a_q    <= '0;
            pkt_b_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            err_seen_q <= err_seen_d;
            pkt_a_q    <= pkt_a_d;
            pkt_b_q    <= pkt_b_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        prio_d            = prio_q;
        err_seen_d        = err_seen_q;
        pkt_a_d           = pkt_a_q;
        pkt_b_d           = pkt_b_q;
        err_d             = err_q;
        a_axis_tready_o   = 1'b0;
        b_axis_tready_o   = 1'b0;
        upd_axis_tvalid_o = 1'b0;
        upd_axis_tkeep_o  = '0;
        upd_axis_tdata_o  = '0;
        upd_axis_tlast_o  = 1'b0;
        upd_axis_tuser_o  = 1'b0;
        xfer              = 1'b0;

        unique case (state_q)
            IDLE: begin
                // prio only matters when both feeds contend
                if (a_axis_tvalid_i && (!b_axis_tvalid_i || !prio_q))
                    state_d = GNT_A;
                else if (b_axis_tvalid_i)
                    state_d = GNT_B;
            end
            GNT_A: begin
                upd_axis_tvalid_o = a_axis_tvalid_i;
                upd_axis_tkeep_o  = a_axis_tkeep_i;
                upd_axis_tdata_o  = a_axis_tdata_i;
                upd_axis_tlast_o  = a_axis_tlast_i;
                upd_axis_tuser_o  = a_axis_tuser_i;
                a_axis_tready_o   = upd_axis_tready_i;
            end
            GNT_B: begin
                upd_axis_tvalid_o = b_axis_tvalid_i;
                upd_axis_tkeep_o  = b_axis_tkeep_i;
                upd_axis_tdata_o  = b_axis_tdata_i;
                upd_axis_tlast_o  = b_axis_tlast_i;
                upd_axis_tuser_o  = b_axis_tuser_i;
                b_axis_tready_o   = upd_axis_tready_i;
            end
            default: state_d = IDLE;
        endcase

        xfer = upd_axis_tvalid_o && upd_axis_tready_i;

        if (xfer) begin
            if (upd_axis_tlast_o) begin
                // packet end: release grant, hand priority to the other feed
                state_d    = IDLE;
                err_seen_d = 1'b0;
                prio_d     = (state_q == GNT_A);
                if (err_seen_q || upd_axis_tuser_o)
                    err_d = err_q + CNT_W'(1);
                if (state_q == GNT_A)
                    pkt_a_d = pkt_a_q + CNT_W'(1);
                else
                    pkt_b_d = pkt_b_q + CNT_W'(1);
            end else begin
                err_seen_d = err_seen_q || upd_axis_tuser_o;
            end
        end
    end

    assign grant_o     = {state_q == GNT_B, state_q == GNT_A};
    assign pkt_a_cnt_o = pkt_a_q;
    assign pkt_b_cnt_o = pkt_b_q;
    assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_mold_feed_arb.sv
// tb_mold_feed_arb: directed stimulus with a scoreboard queue of expected
// parser-side beats, checked by an independent negedge monitor.
module tb_mold_feed_arb;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int CW = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
        logic          src;
    } beat_t;
    typedef beat_t bq_t[$];

    logic          clk = 1'b0;
    logic          nreset;
    logic          av, al, au, bv, bl, bu;
    logic [KW-1:0] ak, bk;
    logic [DW-1:0] ad, bd;
    logic          a_tready, b_tready;
    logic          upd_tvalid, upd_tlast, upd_tuser;
    logic [KW-1:0] upd_tkeep;
    logic [DW-1:0] upd_tdata;
    logic          ptready;
    logic [1:0]    grant;
    logic [CW-1:0] pkt_a, pkt_b, err_cnt;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    mold_feed_arb #(.AXI_DATA_W(DW), .AXI_KEEP_W(KW), .CNT_W(CW)) dut (
        .clk(clk), .nreset(nreset),
        .a_axis_tvalid_i(av), .a_axis_tkeep_i(ak), .a_axis_tdata_i(ad),
        .a_axis_tlast_i(al), .a_axis_tuser_i(au), .a_axis_tready_o(a_tready),
        .b_axis_tvalid_i(bv), .b_axis_tkeep_i(bk), .b_axis_tdata_i(bd),
        .b_axis_tlast_i(bl), .b_axis_tuser_i(bu), .b_axis_tready_o(b_tready),
        .upd_axis_tvalid_o(upd_tvalid), .upd_axis_tkeep_o(upd_tkeep),
        .upd_axis_tdata_o(upd_tdata), .upd_axis_tlast_o(upd_tlast),
        .upd_axis_tuser_o(upd_tuser), .upd_axis_tready_i(ptready),
        .grant_o(grant), .pkt_a_cnt_o(pkt_a), .pkt_b_cnt_o(pkt_b),
        .err_cnt_o(err_cnt)
    );

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setf(input bit f, input logic v, input beat_t b);
        if (!f) begin
            av = v; ad = b.d; ak = b.k; al = b.l; au = b.u;
        end else begin
            bv = v; bd = b.d; bk = b.k; bl = b.l; bu = b.u;
        end
    endtask

    function automatic beat_t zb();
        beat_t z;
        z = '{d: '0, k: '0, l: 1'b0, u: 1'b0, src: 1'b0};
        return z;
    endfunction

    function automatic bq_t mk(input bit src, input int n,
                               input logic [DW-1:0] base, input bit err0);
        bq_t q;
        for (int i = 0; i < n; i++)
            q.push_back('{d: base + DW'(i), k: 8'hFF, l: (i == n - 1),
                          u: (err0 && i == 0), src: src});
        return q;
    endfunction

    task automatic push(input bq_t p);
        foreach (p[i]) exp_q.push_back(p[i]);
    endtask

    // wait for the presented beat to be accepted; returns at posedge+1
    task automatic wait_xfer(input bit f);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (f ? b_tready : a_tready) break;
            t++;
            if (t > 200) begin
                errors++;
                $display("FAIL xfer_timeout feed %0d: got no tready expected tready", f);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit f, input bq_t p, input int gap_at,
                         input int gap_len);
        foreach (p[i]) begin
            if (i == gap_at) begin
                setf(f, 1'b0, zb());
                repeat (gap_len) step();
            end
            setf(f, 1'b1, p[i]);
            wait_xfer(f);
        end
        setf(f, 1'b0, zb());
    endtask

    task automatic chk_cnt(input string tag, input int ea, input int eb,
                           input int ee);
        chk({tag, "_pkt_a"}, pkt_a, CW'(ea));
        chk({tag, "_pkt_b"}, pkt_b, CW'(eb));
        chk({tag, "_err"}, err_cnt, CW'(ee));
        chk({tag, "_grant_idle"}, grant, 2'b00);
    endtask

    // monitor: idle pins, tready gating and scoreboard comparison
    always @(negedge clk) begin
        beat_t e;
        if (nreset) begin
            if (grant == 2'b00)
                chk("idle_pins", {upd_tvalid, a_tready, b_tready,
                     |upd_tdata, |upd_tkeep, upd_tlast, upd_tuser}, 0);
            else if (grant == 2'b01) begin
                chk("b_tready_blocked", b_tready, 0);
                chk("a_tready_pass", a_tready, ptready);
            end else if (grant == 2'b10) begin
                chk("a_tready_blocked", a_tready, 0);
                chk("b_tready_pass", b_tready, ptready);
            end else
                chk("grant_onehot", grant, 2'b01);
            if (upd_tvalid && ptready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got data %0h expected none", upd_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_src", grant, e.src ? 2'b10 : 2'b01);
                    chk("beat_data", upd_tdata, e.d);
                    chk("beat_keep", upd_tkeep, e.k);
                    chk("beat_last", upd_tlast, e.l);
                    chk("beat_user", upd_tuser, e.u);
                end
            end
        end
    end

    bit done;

    initial begin
        bq_t p, q, pa, pb;
        beat_t b;

        // reset values with both feeds valid
        nreset = 1'b0;
        ptready = 1'b1;
        b = '{d: 64'h1234, k: 8'hFF, l: 1'b0, u: 1'b1, src: 1'b0};
        setf(0, 1'b1, b);
        setf(1, 1'b1, b);
        repeat (2) step();
        chk("rst_a_tready", a_tready, 0);
        chk("rst_b_tready", b_tready, 0);
        chk("rst_upd_tvalid", upd_tvalid, 0);
        chk("rst_upd_tdata", upd_tdata, 0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_pkt_a", pkt_a, 0);
        chk("rst_pkt_b", pkt_b, 0);
        chk("rst_err", err_cnt, 0);
        setf(0, 1'b0, zb());
        setf(1, 1'b0, zb());
        step();
        nreset = 1'b1;
        step();

        // single feed A, 3 beats; first beat one cycle after valid
        p = {};
        p.push_back('{d: 64'hDEADBEEF, k: 8'hFF, l: 1'b0, u: 1'b0, src: 1'b0});
        p.push_back('{d: 64'hF0F0F0F0F0F0F0F0, k: 8'hFF, l: 1'b0, u: 1'b0, src: 1'b0});
        p.push_back('{d: 64'hABCD, k: 8'h03, l: 1'b1, u: 1'b0, src: 1'b0});
        push(p);
        fork
            drive(0, p, -1, 0);
            begin
                #2;
                chk("lat_no_out_yet", upd_tvalid, 0);
                @(posedge clk);
                #2;
                chk("lat_grant_a", grant, 2'b01);
                chk("lat_first_valid", upd_tvalid, 1);
            end
        join
        chk_cnt("single", 1, 0, 0);

        // B packet with tuser on beat 0, then a clean B packet
        p = mk(1, 3, 64'hB000, 1);
        push(p);
        drive(1, p, -1, 0);
        chk_cnt("errpkt", 1, 1, 1);
        p = mk(1, 2, 64'hB100, 0);
        push(p);
        drive(1, p, -1, 0);
        chk_cnt("cleanpkt", 1, 2, 1);

        // contention: prio is A here, expect A,B,A,B
        pa = mk(0, 2, 64'hA200, 0);
        q = mk(0, 2, 64'hA300, 0);
        pb = mk(1, 2, 64'hB200, 0);
        p = mk(1, 2, 64'hB300, 0);
        push(pa); push(pb); push(q); push(p);
        pa = {pa, q};
        pb = {pb, p};
        fork
            drive(0, pa, -1, 0);
            drive(1, pb, -1, 0);
        join
        chk_cnt("contend", 3, 4, 1);

        // backpressure: parser tready toggles during an A packet, B waiting
        pa = mk(0, 4, 64'hA400, 0);
        pb = mk(1, 2, 64'hB400, 0);
        push(pa); push(pb);
        done = 1'b0;
        fork
            begin drive(0, pa, -1, 0); done = 1'b1; end
            begin step(); drive(1, pb, -1, 0); end
            begin
                while (!done) begin
                    step();
                    ptready = ~ptready;
                end
                ptready = 1'b1;
            end
        join
        chk_cnt("bp", 4, 5, 1);

        // A drops tvalid for 5 cycles mid-packet; B must not be granted
        pa = mk(0, 4, 64'hA500, 0);
        pb = mk(1, 1, 64'hB500, 0);
        push(pa); push(pb);
        fork
            drive(0, pa, 2, 5);
            begin step(); drive(1, pb, -1, 0); end
            begin
                repeat (4) step();
                chk("stall_grant_held", grant, 2'b01);
            end
        join
        chk_cnt("stall", 5, 6, 1);

        // A packet so prio points at B, then reset on beat 2 of a B packet
        p = mk(0, 1, 64'hA600, 0);
        push(p);
        drive(0, p, -1, 0);
        chk_cnt("pre_rst", 6, 6, 1);
        p = mk(1, 4, 64'hB600, 0);
        exp_q.push_back(p[0]);
        exp_q.push_back(p[1]);
        setf(1, 1'b1, p[0]);
        wait_xfer(1);
        setf(1, 1'b1, p[1]);
        wait_xfer(1);
        setf(1, 1'b1, p[2]);
        nreset = 1'b0;
        #1;
        chk("mid_rst_tvalid", upd_tvalid, 0);
        chk("mid_rst_tdata", upd_tdata, 0);
        chk("mid_rst_b_tready", b_tready, 0);
        chk("mid_rst_grant", grant, 2'b00);
        chk("mid_rst_pkt_a", pkt_a, 0);
        chk("mid_rst_pkt_b", pkt_b, 0);
        chk("mid_rst_err", err_cnt, 0);
        setf(1, 1'b0, zb());
        step();
        nreset = 1'b1;
        step();
        pa = mk(0, 1, 64'hA700, 0);
        pb = mk(1, 1, 64'hB700, 0);
        push(pa); push(pb);
        fork
            drive(0, pa, -1, 0);
            drive(1, pb, -1, 0);
        join
        chk_cnt("post_rst", 1, 1, 0);

        // 255 more A packets: A count reaches 2^CW and wraps to 0
        p = {};
        for (int i = 0; i < 255; i++) begin
            b = '{d: DW'(i), k: 8'hFF, l: 1'b1, u: 1'b0, src: 1'b0};
            p.push_back(b);
        end
        push(p);
        drive(0, p, -1, 0);
        chk_cnt("wrap", 0, 1, 0);

        step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
